vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter CREDIT_W, 4: credit width in 0.5-yuan units.
REQ-002 Parameter MAX_CREDIT, 10: credit ceiling in 0.5-yuan units (5.0 yuan).
REQ-003 Parameter TIMEOUT_CYC, 1000: idle-credit timeout in clk cycles (used only when VEND_TIMEOUT_EN is defined).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 coin_half  input  1  one-cycle pulse: 0.5-yuan coin inserted.
REQ-007 coin_one  input  1  one-cycle pulse: 1-yuan coin inserted.
REQ-008 coin_reject  output  1  one-cycle pulse: the coin inserted in this same cycle is returned, not credited.
REQ-009 sel_valid  input  1  one-cycle pulse: drink selection request.
REQ-010 sel_id  input  2  selected drink slot.
REQ-011 sel_price  input  CREDIT_W  price of sel_id in 0.5-yuan units; valid with sel_valid.
REQ-012 sel_nack  output  1  one-cycle pulse: selection refused (sel_price > credit, sel_price == 0, or not in ACCEPT).
REQ-013 cancel  input  1  one-cycle pulse: refund request.
REQ-014 vend_req / vend_id  output  1 / 2  dispense request and slot to the motor driver.
REQ-015 vend_ack  input  1  motor driver completion; consumed only while vend_req is high.
REQ-016 chg_req / chg_type  output  1 / 1  change-coin request; chg_type 0 = 0.5 yuan, 1 = 1 yuan.
REQ-017 chg_ack  input  1  hopper has ejected one coin; consumed only while chg_req is high.
REQ-018 credit  output  CREDIT_W  current credit register.
REQ-019 busy  output  1  high in VEND or CHANGE.

Function
REQ-020 States: ACCEPT, VEND, CHANGE; encodings come from vend_pkg.
REQ-021 ACCEPT: each coin is credited next cycle (+1 half, +2 one) if the result ≤ MAX_CREDIT; otherwise coin_reject pulses in the same cycle and credit is unchanged.
REQ-022 Simultaneous coin_half and coin_one: coin_one is evaluated first, then coin_half against the updated sum; either coin that does not fit is rejected.
REQ-023 Outside ACCEPT, every coin is rejected (combinational coin_reject).
REQ-024 ACCEPT with sel_valid, sel_price ≠ 0 and sel_price ≤ credit (pre-coin value): credit ← credit − sel_price, and coins arriving in that cycle are rejected; next state is VEND.
REQ-025 ACCEPT with sel_valid when the condition in REQ-024 fails: sel_nack pulses in the same cycle and the state is unchanged.
REQ-026 cancel has priority over sel_valid in the same cycle: if credit > 0, go to CHANGE; if credit == 0, no action; the selection is nacked.
REQ-027 VEND: vend_req = 1 and vend_id is held stable until vend_ack; on ack, go to CHANGE if credit > 0, else ACCEPT.
REQ-028 VEND and CHANGE: sel_valid gives sel_nack; cancel is ignored.
REQ-029 CHANGE: chg_req = 1; chg_type = 1 if credit ≥ 2, else 0; both are held stable until chg_ack.
REQ-030 On chg_ack: credit decrements by 2 or 1; if it reaches 0, go to ACCEPT with chg_req low in the following cycle.
REQ-031 vend_req and chg_req are never high together; a 0-wait ack (same cycle as req assertion) is legal.

Reset
REQ-032 During reset: state = ACCEPT; credit = 0; all outputs are 0 except the combinational coin_reject and sel_nack, which follow REQ-021/025 on inputs.
REQ-033 Reset mid-VEND or mid-CHANGE drops requests immediately and discards credit; no refund.

Configuration
REQ-034 Macro VEND_TIMEOUT_EN defined: a counter runs in ACCEPT while credit > 0 and clears on any coin, sel_valid or cancel; at TIMEOUT_CYC, enter CHANGE (auto-refund).
REQ-035 VEND_TIMEOUT_EN undefined: no counter, and credit is held indefinitely.

Structure
REQ-036 Package vend_pkg holds the state enum, the chg_type constants (CHG_HALF, CHG_ONE), and the coin values HALF_U = 1 and ONE_U = 2.
REQ-037 Sub-module vend_change_engine implements the CHANGE coin-selection and handshake (REQ-029, REQ-030); everything else stays in vend_sequencer.

Verification
REQ-038 Coin sequence one, one, half then sel_price = 5: credit goes 2, 4, 5, then 0; vend_req is held until vend_ack; no chg_req is issued.
REQ-039 Coins one ×3 then sel_price = 5: credit 6 → 1; VEND, then CHANGE issues one chg_type 0; ACCEPT with credit 0.
REQ-040 Credit 9, then coin_one: coin_reject pulses and credit stays 9; coin_half and coin_one in the same cycle at credit 8: one is accepted, half is rejected, credit = 10.
REQ-041 Credit 3, sel_price = 5: sel_nack pulses and credit stays 3; then cancel: change is one 1-yuan coin then one 0.5-yuan coin, each held until a delayed chg_ack (3 cycles).
REQ-042 Reset asserted during CHANGE with credit 4: outputs clear asynchronously; after release, state is ACCEPT with credit 0.
REQ-043 With VEND_TIMEOUT_EN defined, TIMEOUT_CYC = 20, credit 2 and no activity: CHANGE is entered after 20 cycles and one chg_type 1 coin is returned.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: FSM states, change-coin
// type codes and coin values in 0.5-yuan units.
package vend_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic CHG_HALF = 1'b0;
  localparam logic CHG_ONE  = 1'b1;

  localparam int HALF_U = 1;
  localparam int ONE_U  = 2;

endpackage

// File: rtl/vend_sequencer_if.sv
// Coin, selection, dispense and change-hopper signals of the vending sequencer.
// slave is the sequencer side, master is the machine/environment side.
interface vend_sequencer_if #(
  parameter int CREDIT_W = 4
);
  logic                coin_half;
  logic                coin_one;
  logic                coin_reject;
  logic                sel_valid;
  logic [1:0]          sel_id;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_nack;
  logic                cancel;
  logic                vend_req;
  logic [1:0]          vend_id;
  logic                vend_ack;
  logic                chg_req;
  logic                chg_type;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport slave (
    input  coin_half, coin_one, sel_valid, sel_id, sel_price, cancel,
           vend_ack, chg_ack,
    output coin_reject, sel_nack, vend_req, vend_id, chg_req, chg_type,
           credit, busy
  );

  modport master (
    output coin_half, coin_one, sel_valid, sel_id, sel_price, cancel,
           vend_ack, chg_ack,
    input  coin_reject, sel_nack, vend_req, vend_id, chg_req, chg_type,
           credit, busy
  );

endinterface

// File: rtl/vend_change_engine.sv
// Change payout: picks the largest coin that fits the remaining credit and
// handshakes it with the hopper; the owner of the credit register applies the step.
module vend_change_engine
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                chg_ack,
  output logic                chg_req,
  output logic                chg_type,
  output logic                take,
  output logic [CREDIT_W-1:0] credit_next,
  output logic                done
);

  logic use_one;

  // credit only moves on an ack, so req/type stay stable while the hopper works
  assign use_one     = credit >= CREDIT_W'(ONE_U);
  assign chg_req     = active;
  assign chg_type    = (active && use_one) ? CHG_ONE : CHG_HALF;
  assign take        = active && chg_ack;
  assign credit_next = credit - (use_one ? CREDIT_W'(ONE_U) : CREDIT_W'(HALF_U));
  assign done        = take && (credit_next == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: coin crediting, selection, dispense and change.
// Define VEND_TIMEOUT_EN to auto-refund credit left idle for TIMEOUT_CYC cycles.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic              clk,
  input logic              reset,
  vend_sequencer_if.slave  bus
);

  localparam int SUM_W = CREDIT_W + 1;

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit, credit_next;
  logic [1:0]          vend_id;
  logic [SUM_W-1:0]    base_one, base_half, coin_sum;
  logic                sel_ok, one_ok, half_ok, coin_en;
  logic                chg_take, chg_done, timeout_hit;
  logic [CREDIT_W-1:0] chg_credit_next;

  // coin_one is judged first, coin_half against the sum it leaves
  assign base_one  = {1'b0, credit} + SUM_W'(ONE_U);
  assign one_ok    = coin_en && bus.coin_one && (base_one <= SUM_W'(MAX_CREDIT));
  assign base_half = (one_ok ? base_one : {1'b0, credit}) + SUM_W'(HALF_U);
  assign half_ok   = coin_en && bus.coin_half && (base_half <= SUM_W'(MAX_CREDIT));
  assign coin_sum  = {1'b0, credit} + (one_ok ? SUM_W'(ONE_U) : '0)
                   + (half_ok ? SUM_W'(HALF_U) : '0);

  assign sel_ok  = (state == ACCEPT) && bus.sel_valid && !bus.cancel &&
                   (bus.sel_price != '0) && (bus.sel_price <= credit);
  assign coin_en = (state == ACCEPT) && !sel_ok;

  assign bus.coin_reject = (bus.coin_one && !one_ok) || (bus.coin_half && !half_ok);
  assign bus.sel_nack    = bus.sel_valid && !sel_ok;
  assign bus.vend_req    = (state == VEND);
  assign bus.vend_id     = vend_id;
  assign bus.credit      = credit;
  assign bus.busy        = (state != ACCEPT);

  vend_change_engine #(.CREDIT_W(CREDIT_W)) u_change (
    .active      (state == CHANGE),
    .credit      (credit),
    .chg_ack     (bus.chg_ack),
    .chg_req     (bus.chg_req),
    .chg_type    (bus.chg_type),
    .take        (chg_take),
    .credit_next (chg_credit_next),
    .done        (chg_done)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            activity;

  assign activity    = bus.coin_half || bus.coin_one || bus.sel_valid || bus.cancel;
  assign timeout_hit = (state == ACCEPT) && (credit != '0) && !activity &&
                       (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      idle_cnt <= '0;
    else if ((state != ACCEPT) || (credit == '0) || activity || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ACCEPT;
      credit  <= '0;
      vend_id <= '0;
    end else begin
      state  <= state_next;
      credit <= credit_next;
      if (sel_ok)
        vend_id <= bus.sel_id;
    end
  end

  // coins landing with a cancel are still credited and so refunded with the rest
  always_comb begin
    state_next  = state;
    credit_next = credit;
    case (state)
      ACCEPT: begin
        if (sel_ok) begin
          credit_next = credit - bus.sel_price;
          state_next  = VEND;
        end else begin
          credit_next = coin_sum[CREDIT_W-1:0];
          if ((bus.cancel && (credit != '0)) || timeout_hit)
            state_next = CHANGE;
        end
      end
      VEND: begin
        if (bus.vend_ack)
          state_next = (credit != '0) ? CHANGE : ACCEPT;
      end
      CHANGE: begin
        if (chg_take)
          credit_next = chg_credit_next;
        if (chg_done)
          state_next = ACCEPT;
      end
      default: state_next = ACCEPT;
    endcase
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer; expectations are hand-computed.
// Define VEND_TIMEOUT_EN to also exercise the idle auto-refund.
module tb_vend_sequencer;
  import vend_pkg::*;

  localparam int CREDIT_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ones, halves, n;

  vend_sequencer_if #(.CREDIT_W(CREDIT_W)) bus ();

  vend_sequencer #(
    .CREDIT_W    (CREDIT_W),
    .MAX_CREDIT  (10),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    bus.coin_half = 1'b0;
    bus.coin_one  = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_id    = 2'd0;
    bus.sel_price = '0;
    bus.cancel    = 1'b0;
    bus.vend_ack  = 1'b0;
    bus.chg_ack   = 1'b0;
  endtask

  // drive one cycle's inputs mid-low-phase, leaving time to sample combinational outputs
  task automatic applyStimulus(input logic half, input logic one, input logic sv,
                               input logic [1:0] id, input logic [3:0] price,
                               input logic cn, input logic vack, input logic cack);
    @(negedge clk);
    bus.coin_half = half;
    bus.coin_one  = one;
    bus.sel_valid = sv;
    bus.sel_id    = id;
    bus.sel_price = price;
    bus.cancel    = cn;
    bus.vend_ack  = vack;
    bus.chg_ack   = cack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic coin(input logic half, input logic one);
    applyStimulus(half, one, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drainChange(output int n_one, output int n_half);
    n_one  = 0;
    n_half = 0;
    for (int i = 0; i < 20 && bus.chg_req; i++) begin
      if (bus.chg_type) n_one++;
      else              n_half++;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    checkOutput("drain_finished", bus.chg_req, 0);
    checkOutput("drain_credit", bus.credit, 0);
  endtask

  initial begin
    clearInputs();
    #12;
    checkOutput("rst_credit", bus.credit, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_vend_req", bus.vend_req, 0);
    checkOutput("rst_chg_req", bus.chg_req, 0);
    checkOutput("rst_chg_type", bus.chg_type, 0);
    checkOutput("rst_vend_id", bus.vend_id, 0);
    @(negedge clk);
    reset = 1'b1;

    // one, one, half, buy at 5: exact credit, no change
    coin(1'b0, 1'b1);  checkOutput("t1_credit_2", bus.credit, 2);
    coin(1'b0, 1'b1);  checkOutput("t1_credit_4", bus.credit, 4);
    coin(1'b1, 1'b0);  checkOutput("t1_credit_5", bus.credit, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_sel_nack", bus.sel_nack, 0);
    tick();
    checkOutput("t1_credit_0", bus.credit, 0);
    checkOutput("t1_vend_req", bus.vend_req, 1);
    checkOutput("t1_vend_id", bus.vend_id, 2);
    checkOutput("t1_busy", bus.busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_vend_sel_nack", bus.sel_nack, 1);
    checkOutput("t1_vend_coin_reject", bus.coin_reject, 1);
    tick();
    checkOutput("t1_vend_req_held", bus.vend_req, 1);
    checkOutput("t1_vend_id_held", bus.vend_id, 2);
    checkOutput("t1_no_chg", bus.chg_req, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t1_vend_done", bus.vend_req, 0);
    checkOutput("t1_idle_busy", bus.busy, 0);
    checkOutput("t1_idle_chg", bus.chg_req, 0);

    // three ones, buy at 5: one half-yuan coin back
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    checkOutput("t2_credit_6", bus.credit, 6);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t2_credit_1", bus.credit, 1);
    checkOutput("t2_vend_req", bus.vend_req, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t2_chg_req", bus.chg_req, 1);
    checkOutput("t2_chg_type", bus.chg_type, CHG_HALF);
    checkOutput("t2_vend_off", bus.vend_req, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t2_credit_0", bus.credit, 0);
    checkOutput("t2_chg_off", bus.chg_req, 0);
    checkOutput("t2_busy", bus.busy, 0);

    // ceiling: both coins at 8, then a one at 9
    for (int i = 0; i < 4; i++) coin(1'b0, 1'b1);
    checkOutput("t3_credit_8", bus.credit, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_both_reject", bus.coin_reject, 1);
    tick();
    checkOutput("t3_credit_10", bus.credit, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("t3_cancel_busy", bus.busy, 1);
    drainChange(ones, halves);
    checkOutput("t3_refund10_ones", ones, 5);
    checkOutput("t3_refund10_halves", halves, 0);
    for (int i = 0; i < 4; i++) coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    checkOutput("t3_credit_9", bus.credit, 9);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_one_reject", bus.coin_reject, 1);
    tick();
    checkOutput("t3_credit_9_kept", bus.credit, 9);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drainChange(ones, halves);
    checkOutput("t3_refund9_ones", ones, 4);
    checkOutput("t3_refund9_halves", halves, 1);

    // refused selections, then a slow-hopper refund of 3
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_nack_price", bus.sel_nack, 1);
    tick();
    checkOutput("t4_credit_3", bus.credit, 3);
    checkOutput("t4_not_busy", bus.busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_nack_zero", bus.sel_nack, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_nack_cancel", bus.sel_nack, 1);
    tick();
    checkOutput("t4_chg_req", bus.chg_req, 1);
    checkOutput("t4_chg_one", bus.chg_type, CHG_ONE);
    checkOutput("t4_chg_credit", bus.credit, 3);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("t4_chg_coin_reject", bus.coin_reject, 1);
      tick();
      checkOutput("t4_one_held_req", bus.chg_req, 1);
      checkOutput("t4_one_held_type", bus.chg_type, CHG_ONE);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t4_credit_1", bus.credit, 1);
    checkOutput("t4_half_req", bus.chg_req, 1);
    checkOutput("t4_half_type", bus.chg_type, CHG_HALF);
    for (int i = 0; i < 2; i++) begin
      idle();
      checkOutput("t4_half_held_req", bus.chg_req, 1);
      checkOutput("t4_half_held_type", bus.chg_type, CHG_HALF);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t4_credit_0", bus.credit, 0);
    checkOutput("t4_chg_off", bus.chg_req, 0);
    checkOutput("t4_busy_off", bus.busy, 0);

    // asynchronous reset in the middle of a refund
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    checkOutput("t5_credit_4", bus.credit, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("t5_chg_req", bus.chg_req, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("t5_rst_chg_req", bus.chg_req, 0);
    checkOutput("t5_rst_chg_type", bus.chg_type, 0);
    checkOutput("t5_rst_busy", bus.busy, 0);
    checkOutput("t5_rst_credit", bus.credit, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    checkOutput("t5_post_credit", bus.credit, 0);
    checkOutput("t5_post_busy", bus.busy, 0);
    coin(1'b0, 1'b1);
    checkOutput("t5_post_coin", bus.credit, 2);

`ifdef VEND_TIMEOUT_EN
    n = 0;
    while (!bus.busy && n < 40) begin
      idle();
      n++;
    end
    checkOutput("t6_timeout_cycles", n, 20);
    checkOutput("t6_chg_type", bus.chg_type, CHG_ONE);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t6_credit_0", bus.credit, 0);
    checkOutput("t6_busy_off", bus.busy, 0);
`else
    for (int i = 0; i < 30; i++) idle();
    checkOutput("t6_credit_held", bus.credit, 2);
    checkOutput("t6_no_refund", bus.busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
